serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH SHALL be declared as: WIDTH, default 4, operand and result bit width (legal range 2..16).
REQ-002 Port clk SHALL be declared as: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst_n SHALL be declared as: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port in_valid SHALL be declared as: in_valid  input  1  operands A and B are presented.
REQ-005 Port in_ready SHALL be declared as: in_ready  output  1  block can accept operands.
REQ-006 Port A SHALL be declared as: A  input  WIDTH  minuend.
REQ-007 Port B SHALL be declared as: B  input  WIDTH  subtrahend.
REQ-008 Port out_valid SHALL be declared as: out_valid  output  1  result fields are valid.
REQ-009 Port out_ready SHALL be declared as: out_ready  input  1  consumer accepts the result.
REQ-010 Port diff SHALL be declared as: diff  output  WIDTH  (A - B) mod 2^WIDTH.
REQ-011 Port borrow SHALL be declared as: borrow  output  1  unsigned borrow out; 1 iff A < B.
REQ-012 Port overflow SHALL be declared as: overflow  output  1  signed two's-complement overflow.

Function
REQ-013 The block SHALL have the states IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 out_valid SHALL be 1 only in DONE.
REQ-016 Accept: on a rising edge with in_valid=1 and in_ready=1, the block SHALL capture A and B into shift registers, clear the borrow flop, zero the bit counter and go to SHIFT.
REQ-017 In SHIFT, each cycle SHALL compute one bit, LSB first, via a 1-bit full subtractor: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
REQ-018 In SHIFT, each cycle SHALL shift d into diff from the MSB end, update the borrow flop and increment the counter.
REQ-019 After exactly WIDTH SHIFT cycles the block SHALL enter DONE: out_valid rises WIDTH edges after the accepting edge.
REQ-020 On entering DONE, borrow SHALL equal the final borrow out.
REQ-021 On entering DONE, overflow SHALL equal (A[MSB]!=B[MSB]) && (diff[MSB]!=A[MSB]), using the captured A and B.
REQ-022 diff, borrow and overflow SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 The block SHALL return to IDLE on the edge where out_valid=1 and out_ready=1.
REQ-024 in_ready SHALL rise one cycle after that edge; there is no accept/complete overlap.
REQ-025 in_valid asserted during SHIFT or DONE SHALL be ignored; A and B changing mid-operation SHALL NOT affect the result.
REQ-026 Wrap-around: A < B SHALL yield the two's-complement diff with borrow=1; A == B SHALL yield diff=0, borrow=0, overflow=0.
REQ-027 diff, borrow and overflow SHALL be undefined-free: they SHALL retain the last result while in IDLE.

Reset
REQ-028 rst_n=0 SHALL, at any time including mid-SHIFT or in DONE, immediately force state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, overflow=0, counter=0 and operand registers=0.
REQ-029 An in-flight operation SHALL be discarded by reset and SHALL produce no out_valid after release.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package arith_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default WIDTH constant; the counter width SHALL be $clog2(WIDTH+1).
REQ-032 One sub-module, full_subtractor, SHALL be used (inputs a, b, bin; outputs d, bout; combinational).
REQ-033 Everything else SHALL be in serial_subtractor; target size is 120-400 RTL lines.

Verification
REQ-034 Test 5-3: A=0101, B=0011, out_ready=1 -> out_valid at accept+4, diff=0010, borrow=0, overflow=0.
REQ-035 Test 10-2: A=1010, B=0010 -> diff=1000, borrow=0, overflow=0.
REQ-036 Test 2-7: A=0010, B=0111 -> diff=1011, borrow=1, overflow=0.
REQ-037 Test 7-(-8): A=0111, B=1000 -> diff=1111, borrow=1, overflow=1; also A=B=1010 -> diff=0000, borrow=0, overflow=0.
REQ-038 Test backpressure: out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0 throughout; a new in_valid pulse meanwhile is ignored; on out_ready=1 -> IDLE next cycle.
REQ-039 Test reset mid-operation: assert rst_n=0 two cycles into SHIFT -> outputs zero immediately, in_ready=1; then accept 5-3 -> diff=0010 at accept+4.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the serial subtractor.
//   state_t   : control states of the bit-serial engine
//   WIDTH_DEF : default operand/result width
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
// Ports:
//   a, b  : minuend / subtrahend bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned/two's-complement subtractor. Operands are captured on
// a valid/ready handshake, processed LSB first over WIDTH cycles, and the
// result is held under a valid/ready output handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only when idle)
//   A, B                : minuend, subtrahend
//   out_valid/out_ready : result handshake
//   diff                : (A - B) mod 2^WIDTH
//   borrow              : 1 iff A < B (unsigned)
//   overflow            : signed two's-complement overflow
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int                CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fs_d;
  logic fs_bout;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (brw_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Operands shift right so bit 0 is always the current bit; on the
        // last cycle bit 0 holds the original sign bits of A and B.
        a_d    = {1'b0, a_q[WIDTH-1:1]};
        b_d    = {1'b0, b_q[WIDTH-1:1]};
        diff_d = {fs_d, diff_q[WIDTH-1:1]};
        brw_d  = fs_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          ovf_d   = (a_q[0] ^ b_q[0]) & (fs_d ^ a_q[0]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = brw_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] diff;
  logic       borrow;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       br;
    logic       ov;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller is positioned at a negedge. Drives operands, lets the next
  // posedge accept them, scrambles the inputs, then waits for out_valid.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b,
                          input logic ordy, output int lat);
    A = a; B = b; in_valid = 1'b1; out_ready = ordy;
    chk("in_ready_before_accept", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    A = ~a; B = ~b;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    start_op(v.a, v.b, 1'b1, lat);
    chk({tag, "_latency"},  lat, 4);
    chk({tag, "_diff"},     int'(diff), int'(v.d));
    chk({tag, "_borrow"},   int'(borrow), int'(v.br));
    chk({tag, "_overflow"}, int'(overflow), int'(v.ov));
    @(negedge clk);
    chk({tag, "_idle_ready"}, int'(in_ready), 1);
    chk({tag, "_idle_hold"},  int'(diff), int'(v.d));
  endtask

  initial begin
    int lat;
    logic [3:0] held_d;
    logic held_b, held_o;

    vecs[0] = '{4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0}; // 5-3
    vecs[1] = '{4'b1010, 4'b0010, 4'b1000, 1'b0, 1'b0}; // 10-2
    vecs[2] = '{4'b0010, 4'b0111, 4'b1011, 1'b1, 1'b0}; // 2-7
    vecs[3] = '{4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1}; // 7-(-8)
    vecs[4] = '{4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b0}; // A==B
    vecs[5] = '{4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0}; // 0-1
    vecs[6] = '{4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1}; // -8-1
    vecs[7] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0}; // 15-15
    vecs[8] = '{4'b0011, 4'b0000, 4'b0011, 1'b0, 1'b0}; // 3-0

    // Reset state
    #2;
    chk("rst_in_ready",  int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_diff",      int'(diff), 0);
    chk("rst_borrow",    int'(borrow), 0);
    chk("rst_overflow",  int'(overflow), 0);

    // Release reset and accept on the very first edge afterwards
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], "first_after_reset");

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: hold result for 5 cycles, ignore a new in_valid pulse
    start_op(4'b0101, 4'b0011, 1'b0, lat);
    chk("bp_latency", lat, 4);
    held_d = diff; held_b = borrow; held_o = overflow;
    chk("bp_diff", int'(held_d), 2);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        in_valid = 1'b1; A = 4'b1111; B = 4'b0001;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", k),    int'(out_valid), 1);
      chk($sformatf("bp_ready_%0d", k),    int'(in_ready), 0);
      chk($sformatf("bp_diff_%0d", k),     int'(diff), int'(held_d));
      chk($sformatf("bp_borrow_%0d", k),   int'(borrow), int'(held_b));
      chk($sformatf("bp_overflow_%0d", k), int'(overflow), int'(held_o));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", int'(in_ready), 1);
    chk("bp_release_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("bp_no_phantom", int'(out_valid), 0);
    chk("bp_still_idle", int'(in_ready), 1);

    // Reset two cycles into SHIFT
    A = 4'b1010; B = 4'b0010; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_in_shift", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_diff",      int'(diff), 0);
    chk("mid_rst_borrow",    int'(borrow), 0);
    chk("mid_rst_overflow",  int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("mid_no_valid_%0d", k), int'(out_valid), 0);
    end
    run_vec(vecs[0], "after_mid_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
